// File: rtl/dmem_responder.sv
// Single-port data-memory responder with a configurable number of busy cycles per access.
// Requests are captured on acceptance and completed after WAIT_CYCLES; zero wait completes on the accepting edge.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dm_en_i,
    input  logic        dm_wen_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_din_i,
    output logic        dm_busy_o,
    output logic [31:0] dm_dout_o,
    output logic        dm_err_o
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam int         WAIT_M1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] CNT_INIT  = WAIT_M1[3:0];
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            busy_q;
    logic            err_q;
    logic [31:0]     dout_q;
    logic            wen_q;
    logic            oor_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     din_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            accept;
    logic            req_oor;
    logic [AW-1:0]   req_idx;
    logic            done_d;
    logic            op_wen_d;
    logic            op_oor_d;
    logic [AW-1:0]   op_idx_d;
    logic [31:0]     op_din_d;
    logic            mem_we_d;

    assign req_idx = dm_addr_i[AW+1:2];
    assign req_oor = |dm_addr_i[31:AW+2];
    assign accept  = dm_en_i && !busy_q;

    // With zero wait the live request completes on the accepting edge; otherwise the captured copy does.
    always_comb begin
        if (ZERO_WAIT) begin
            done_d   = accept;
            op_wen_d = dm_wen_i;
            op_oor_d = req_oor;
            op_idx_d = req_idx;
            op_din_d = dm_din_i;
        end else begin
            done_d   = (state_q == WAIT) && (cnt_q == 4'd0);
            op_wen_d = wen_q;
            op_oor_d = oor_q;
            op_idx_d = idx_q;
            op_din_d = din_q;
        end
    end

    // Gating with rst_i keeps a zero-wait write from landing while reset is held.
    assign mem_we_d = done_d && op_wen_d && !op_oor_d && !rst_i;

    // NOTE: the storage array has no reset branch; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we_d) begin
            mem_q[op_idx_d] <= op_din_d;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'h0;
            wen_q   <= 1'b0;
            oor_q   <= 1'b0;
            idx_q   <= '0;
            din_q   <= 32'h0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && !ZERO_WAIT) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        wen_q   <= dm_wen_i;
                        oor_q   <= req_oor;
                        idx_q   <= req_idx;
                        din_q   <= dm_din_i;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
            endcase
            if (done_d) begin
                err_q <= op_oor_d;
                if (!op_wen_d) begin
                    dout_q <= op_oor_d ? 32'h0 : mem_q[op_idx_d];
                end
            end
        end
    end

    assign dm_busy_o = busy_q;
    assign dm_dout_o = dout_q;
    assign dm_err_o  = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (2, 0 and 3 wait cycles) driven by directed vectors.
// Expected completions are queued with their due cycle; a negedge monitor compares them against the outputs.
module tb_dmem_responder;
    localparam int WCYC [3] = '{2, 0, 3};

    typedef struct {
        int          d;
        int          due;
        logic [31:0] dout;
        logic        err;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst  [3];
    logic        en   [3];
    logic        wen  [3];
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic        busy [3];
    logic [31:0] dout [3];
    logic        err  [3];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   next_id = 0;
    exp_t sb [$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk_i(clk), .rst_i(rst[0]), .dm_en_i(en[0]), .dm_wen_i(wen[0]),
        .dm_addr_i(addr[0]), .dm_din_i(din[0]),
        .dm_busy_o(busy[0]), .dm_dout_o(dout[0]), .dm_err_o(err[0]));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk), .rst_i(rst[1]), .dm_en_i(en[1]), .dm_wen_i(wen[1]),
        .dm_addr_i(addr[1]), .dm_din_i(din[1]),
        .dm_busy_o(busy[1]), .dm_dout_o(dout[1]), .dm_err_o(err[1]));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk_i(clk), .rst_i(rst[2]), .dm_en_i(en[2]), .dm_wen_i(wen[2]),
        .dm_addr_i(addr[2]), .dm_din_i(din[2]),
        .dm_busy_o(busy[2]), .dm_dout_o(dout[2]), .dm_err_o(err[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int d, input int due, input logic [31:0] xd, input logic xe);
        exp_t e;
        e.d    = d;
        e.due  = due;
        e.dout = xd;
        e.err  = xe;
        e.id   = next_id;
        next_id++;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued completion at the negedge after its completing edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check($sformatf("op%0d_dout", mon_e.id), dout[mon_e.d], mon_e.dout);
            check($sformatf("op%0d_err", mon_e.id), 32'(err[mon_e.d]), 32'(mon_e.err));
        end
    end

    // Called at a negedge, returns at the negedge following the completing edge.
    task automatic do_req(input int d, input logic wr, input logic [31:0] a, input logic [31:0] dv,
                          input logic [31:0] xd, input logic xe);
        int n;
        en[d]   = 1'b1;
        wen[d]  = wr;
        addr[d] = a;
        din[d]  = dv;
        n = 0;
        while (busy[d] === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(busy[d]), 32'd0);
        push_exp(d, cyc + 1 + WCYC[d], xd, xe);
        @(negedge clk);
        en[d]   = 1'b0;
        wen[d]  = 1'b1;
        addr[d] = $urandom;
        din[d]  = $urandom;
        for (int k = 0; k < WCYC[d]; k++) begin
            check("busy_hi", 32'(busy[d]), 32'd1);
            @(negedge clk);
        end
        check("busy_lo", 32'(busy[d]), 32'd0);
    endtask

    // Back-to-back stream for the zero-wait instance.
    localparam int NB = 9;
    logic        b_wr  [NB] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] b_adr [NB] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4, 32'hC, 32'hC, 32'h8};
    logic [31:0] b_din [NB] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                32'h0, 32'h0, 32'h55555555, 32'h0, 32'h0};
    logic [31:0] b_exp [NB] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11111111, 32'h22222222,
                                32'h22222222, 32'h55555555, 32'h33333333};

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; wen[i] = 1'b0; addr[i] = 32'h0; din[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_dout", dout[i], 32'h0);
            check("rst_err", 32'(err[i]), 32'd0);
        end
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Wait-2 instance: first request lands on the first edge after reset release.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req(0, 1'b1, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Request held high with changing inputs while busy: only the captured read counts.
        en[0] = 1'b1; wen[0] = 1'b0; addr[0] = 32'h10; din[0] = 32'h0;
        push_exp(0, cyc + 3, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        addr[0] = 32'h14; wen[0] = 1'b1; din[0] = 32'hBAD0BAD0;
        check("hold_busy1", 32'(busy[0]), 32'd1);
        @(negedge clk);
        addr[0] = 32'h1000; wen[0] = 1'b0;
        check("hold_busy2", 32'(busy[0]), 32'd1);
        @(negedge clk);
        check("hold_done", 32'(busy[0]), 32'd0);
        en[0] = 1'b0;
        @(negedge clk);
        check("hold_no_extra", 32'(busy[0]), 32'd0);
        do_req(0, 1'b0, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0);

        // Range boundaries: top index valid, one past it errors, out-of-range write dropped.
        do_req(0, 1'b1, 32'hFFC, 32'h600DF00D, 32'hCAFEF00D, 1'b0);
        do_req(0, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("err_pulse_end", 32'(err[0]), 32'd0);
        do_req(0, 1'b1, 32'h1010, 32'hFFFFFFFF, 32'h0, 1'b1);
        @(negedge clk);
        check("err_pulse_end_wr", 32'(err[0]), 32'd0);
        do_req(0, 1'b0, 32'hFFC, 32'h0, 32'h600DF00D, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte-offset bits ignored.
        do_req(0, 1'b1, 32'h3, 32'h1, 32'hDEADBEEF, 1'b0);
        do_req(0, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0);

        // Zero-wait instance: one request per edge, busy never raised.
        for (int i = 0; i < NB; i++) begin
            en[1] = 1'b1; wen[1] = b_wr[i]; addr[1] = b_adr[i]; din[1] = b_din[i];
            push_exp(1, cyc + 1, b_exp[i], 1'b0);
            check("w0_busy", 32'(busy[1]), 32'd0);
            @(negedge clk);
        end
        en[1] = 1'b0;
        check("w0_busy_end", 32'(busy[1]), 32'd0);

        // Wait-3 instance: reset mid-wait aborts a write and clears outputs immediately.
        do_req(2, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
        do_req(2, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
        en[2] = 1'b1; wen[2] = 1'b1; addr[2] = 32'h20; din[2] = 32'h12345678;
        @(negedge clk);
        en[2] = 1'b0;
        check("abort_busy1", 32'(busy[2]), 32'd1);
        @(negedge clk);
        check("abort_busy2", 32'(busy[2]), 32'd1);
        rst[2] = 1'b1;
        #1;
        check("abort_busy", 32'(busy[2]), 32'd0);
        check("abort_dout", dout[2], 32'h0);
        check("abort_err", 32'(err[2]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst[2] = 1'b0;
        do_req(2, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, at least 2.
REQ-002 Parameter WAIT_CYCLES, default 2: busy cycles inserted per accepted request; range 0..15.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset; asynchronous and active-high.
REQ-005 dm_en_i  input  1  request valid from the data-cache side.
REQ-006 dm_wen_i  input  1  1 = write, 0 = read; meaningful only with dm_en_i.
REQ-007 dm_addr_i  input  32  byte address; word index = dm_addr_i[AW+1:2], where AW = log2(DEPTH_WORDS).
REQ-008 dm_din_i  input  32  write data.
REQ-009 dm_busy_o  output  1  registered; 1 = request in progress, new requests not accepted.
REQ-010 dm_dout_o  output  32  registered read data.
REQ-011 dm_err_o  output  1  registered; one-cycle pulse on out-of-range completion.

Function
REQ-012 A request SHALL be accepted at a rising edge where dm_en_i=1 and dm_busy_o=0; en, wen, addr and din are captured together at that edge.
REQ-013 The block SHALL use states IDLE and WAIT; a wait counter is 4 bits wide.
REQ-014 WAIT_CYCLES=0: the operation SHALL complete at the accepting edge, dm_busy_o stays 0, and back-to-back requests are accepted on every edge.
REQ-015 WAIT_CYCLES=W>0: at the accepting edge T, state -> WAIT, counter <= W-1, dm_busy_o <= 1.
REQ-016 In WAIT, the counter SHALL decrement each edge; at the edge where the counter equals 0 the operation completes, state -> IDLE, dm_busy_o <= 0; dm_busy_o is therefore high for exactly W cycles (edges T+1..T+W complete at T+W).
REQ-017 Completion of a read SHALL load dm_dout_o with mem[index] at the completing edge; dm_dout_o holds that value until the next read completion.
REQ-018 Completion of a write SHALL write the captured dm_din_i to mem[index]; dm_dout_o is unchanged.
REQ-019 Operations SHALL use only the captured request; input changes while dm_busy_o=1 are ignored.
REQ-020 dm_en_i=1 while dm_busy_o=1 SHALL NOT be queued or accepted; the requester holds the request and it is accepted at the first edge with dm_busy_o=0.
REQ-021 Out-of-range address (any of dm_addr_i[31:AW+2] nonzero): a write is dropped; a read loads dm_dout_o with 32'h0; dm_err_o=1 for the one cycle following the completing edge.
REQ-022 dm_addr_i[1:0] SHALL be ignored (word access only).
REQ-023 A read accepted immediately after a write completes to the same index SHALL return the newly written data.
REQ-024 The top index (DEPTH_WORDS-1) SHALL be a valid address; the index SHALL never wrap to 0.

Reset
REQ-025 rst_i=1 SHALL immediately force state=IDLE, counter=0, dm_busy_o=0, dm_dout_o=32'h0, dm_err_o=0, and clear captured request registers.
REQ-026 Reset during WAIT SHALL abort the request; an aborted write SHALL NOT modify memory.
REQ-027 Memory contents SHALL NOT be cleared by reset; they are undefined after power-up until written.
REQ-028 The first request SHALL be accepted at the first rising edge after rst_i deasserts.

Verification
REQ-029 W=2: write 32'hDEADBEEF to addr 32'h10, then read 32'h10 -> busy high for 2 cycles per request; dout=32'hDEADBEEF after read completion; err=0.
REQ-030 W=2: hold dm_en_i=1 with changing dm_addr_i during busy -> only the captured address is used; no extra request is accepted until busy drops.
REQ-031 W=0: four back-to-back writes/reads to addrs 0,4,8,12 -> busy never asserted; each read's data appears one cycle after its edge.
REQ-032 Read addr 32'h0000_1000 with DEPTH 1024 -> dout=32'h0, err pulses for 1 cycle; read 32'h0000_0FFC -> valid data, no err.
REQ-033 W=3: write 32'h12345678 to 32'h20 (previously 32'hA5A5A5A5), assert rst_i mid-WAIT -> busy=0 and dout=0 immediately; a subsequent read of 32'h20 returns 32'hA5A5A5A5.
REQ-034 Write 32'h1 to 32'h3 then read 32'h0 -> returns 32'h1 (low address bits ignored).
